// File: rtl/bp_fe_pkg.sv
// Shared front-end fetch types: response layout macros, fault priority
// encoding and privilege levels.
`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

`define BP_FE_MEM_PIPE_RESP_WIDTH(vaddr_width_mp, fetch_width_mp) \
  ((vaddr_width_mp) + 32*(fetch_width_mp) + 4)

`define DECLARE_BP_FE_MEM_PIPE_RESP_S(vaddr_width_mp, fetch_width_mp) \
  typedef struct packed {                                \
    logic [(vaddr_width_mp)-1:0]      vaddr;             \
    logic [32*(fetch_width_mp)-1:0]   data;              \
    logic                             itlb_miss;         \
    logic                             instr_page_fault;  \
    logic                             instr_access_fault;\
    logic                             icache_miss;       \
  } bp_fe_mem_pipe_resp_s

package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_fe_fault_none,
    e_fe_fault_itlb_miss,
    e_fe_fault_page,
    e_fe_fault_access
  } bp_fe_fault_e;

  localparam logic [1:0] priv_user       = 2'd0;
  localparam logic [1:0] priv_supervisor = 2'd1;
  localparam logic [1:0] priv_machine    = 2'd3;

endpackage

`endif

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular response buffer, registered output, no bypass (1-cycle min latency).
// Writer must guarantee space (credit scheme upstream); reset_i is active-high.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] rd_ptr, wr_ptr;
  logic [cnt_w_lp-1:0] used;
  logic                deq;

  function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign v_o    = (used != '0);
  assign deq    = yumi_i & v_o;
  assign data_o = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      used   <= '0;
    end else begin
      if (v_i) wr_ptr <= bump(wr_ptr);
      if (deq) rd_ptr <= bump(rd_ptr);
      used <= used + cnt_w_lp'(v_i) - cnt_w_lp'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (v_i) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/bp_fe_mem_pipe.sv
// Fetch-tracking pipeline: pairs ITLB/I$ results with each fetch, classifies faults,
// buffers responses (resp >= stages_p+1 cycles after accept); credit-based cmd_ready_o.
module bp_fe_mem_pipe
  import bp_fe_pkg::*;
#(
  parameter int          vaddr_width_p       = 39,
  parameter int          ptag_width_p        = 28,
  parameter int          page_offset_width_p = 12,
  parameter int          fetch_width_p       = 1,
  parameter int          stages_p            = 2,
  parameter int          buf_els_p           = 2,
  parameter int          io_did_width_p      = 3,
  parameter int unsigned dram_base_ptag_p    = 'h80000
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       cmd_v_i,
  input  logic [vaddr_width_p-1:0]   cmd_vaddr_i,
  output logic                       cmd_ready_o,
  input  logic                       poison_i,
  input  logic [1:0]                 priv_i,
  input  logic                       translation_en_i,
  input  logic                       uncached_mode_i,
  input  logic                       tlb_v_i,
  input  logic                       tlb_miss_i,
  input  logic                       tlb_u_i,
  input  logic                       tlb_x_i,
  input  logic [ptag_width_p-1:0]    tlb_ptag_i,
  input  logic                       uncached_i,
  output logic                       kill_o,
  input  logic [32*fetch_width_p-1:0] cache_data_i,
  input  logic                       cache_data_v_i,
  output logic                       resp_v_o,
  input  logic                       resp_ready_i,
  output logic [`BP_FE_MEM_PIPE_RESP_WIDTH(vaddr_width_p, fetch_width_p)-1:0] resp_o
);

  localparam int resp_width_lp = `BP_FE_MEM_PIPE_RESP_WIDTH(vaddr_width_p, fetch_width_p);
  localparam int cnt_w_lp      = $clog2(buf_els_p + 1);

  `DECLARE_BP_FE_MEM_PIPE_RESP_S(vaddr_width_p, fetch_width_p);

  logic [cnt_w_lp-1:0]      count;
  logic                     accept, deq;
  logic [stages_p:1]        stage_v;
  logic [vaddr_width_p-1:0] stage_vaddr [stages_p:1];
  bp_fe_fault_e             stage_fault [stages_p:2];
  bp_fe_fault_e             fault_s1, last_fault;
  logic                     page_fault, access_fault;
  bp_fe_mem_pipe_resp_s     enq_resp;
  logic [resp_width_lp-1:0] fifo_data;
  logic                     fifo_v, fifo_reset;

  // Credits cover both in-flight stages and buffered entries, so the buffer never overflows.
  assign cmd_ready_o = (count < cnt_w_lp'(buf_els_p));
  assign accept      = cmd_v_i & cmd_ready_o;
  assign deq         = fifo_v & resp_ready_i;

  assign page_fault = translation_en_i & tlb_v_i
                    & (~tlb_x_i
                       | ((priv_i == priv_supervisor) & tlb_u_i)
                       | ((priv_i == priv_user) & ~tlb_u_i));

  assign access_fault = (uncached_mode_i & ~uncached_i)
                      | (tlb_ptag_i[ptag_width_p-1 -: io_did_width_p] != '0)
                      | (tlb_ptag_i < ptag_width_p'(dram_base_ptag_p));

  always_comb begin
    fault_s1 = e_fe_fault_none;
    if (tlb_miss_i)        fault_s1 = e_fe_fault_itlb_miss;
    else if (page_fault)   fault_s1 = e_fe_fault_page;
    else if (access_fault) fault_s1 = e_fe_fault_access;
  end

  assign kill_o = poison_i | (stage_v[1] & (fault_s1 != e_fe_fault_none));

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      stage_v <= '0;
      count   <= '0;
    end else if (poison_i) begin
      // A fetch accepted alongside the redirect belongs to the new path and survives.
      stage_v <= {{(stages_p-1){1'b0}}, accept};
      count   <= cnt_w_lp'(accept);
    end else begin
      stage_v <= {stage_v[stages_p-1:1], accept};
      count   <= count + cnt_w_lp'(accept) - cnt_w_lp'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    stage_vaddr[1] <= cmd_vaddr_i;
    stage_fault[2] <= fault_s1;
    for (int i = 2; i <= stages_p; i++) stage_vaddr[i] <= stage_vaddr[i-1];
    for (int i = 3; i <= stages_p; i++) stage_fault[i] <= stage_fault[i-1];
  end

  assign last_fault = stage_fault[stages_p];

  always_comb begin
    enq_resp                    = '0;
    enq_resp.vaddr              = stage_vaddr[stages_p];
    enq_resp.itlb_miss          = (last_fault == e_fe_fault_itlb_miss);
    enq_resp.instr_page_fault   = (last_fault == e_fe_fault_page);
    enq_resp.instr_access_fault = (last_fault == e_fe_fault_access);
    enq_resp.icache_miss        = (last_fault == e_fe_fault_none) & ~cache_data_v_i;
    enq_resp.data               = (last_fault == e_fe_fault_none) ? cache_data_i : '0;
  end

  assign fifo_reset = ~reset_i | poison_i;

  bsg_fifo_1r1w_small #(
    .width_p (resp_width_lp),
    .els_p   (buf_els_p)
  ) resp_buf (
    .clk_i   (clk_i),
    .reset_i (fifo_reset),
    .v_i     (stage_v[stages_p]),
    .data_i  (enq_resp),
    .v_o     (fifo_v),
    .data_o  (fifo_data),
    .yumi_i  (deq)
  );

  assign resp_v_o = fifo_v;
  assign resp_o   = fifo_v ? fifo_data : '0;

endmodule

// File: tb/tb_bp_fe_mem_pipe.sv
// Directed bench for bp_fe_mem_pipe: three instances (buf_els 3/2/4, stages 2)
// driven from shared inputs with per-instance response ready.
module tb_bp_fe_mem_pipe;

  localparam int vw = 39;
  localparam int pw = 28;
  localparam int rw = vw + 32 + 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_v;
  logic [vw-1:0] cmd_vaddr;
  logic          poison;
  logic [1:0]    priv;
  logic          trans_en, unc_mode;
  logic          tlb_v, tlb_miss, tlb_u, tlb_x;
  logic [pw-1:0] tlb_ptag;
  logic          uncached;
  logic [31:0]   cache_data;
  logic          cache_data_v;
  logic          rdy_a, rdy_b, rdy_c;
  logic          ready_a, ready_b, ready_c;
  logic          kill_a, kill_b, kill_c;
  logic          resp_v_a, resp_v_b, resp_v_c;
  logic [rw-1:0] resp_a, resp_b, resp_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bp_fe_mem_pipe #(.stages_p(2), .buf_els_p(3)) dut_a (
    .clk_i(clk), .reset_i(reset_n), .cmd_v_i(cmd_v), .cmd_vaddr_i(cmd_vaddr),
    .cmd_ready_o(ready_a), .poison_i(poison), .priv_i(priv),
    .translation_en_i(trans_en), .uncached_mode_i(unc_mode), .tlb_v_i(tlb_v),
    .tlb_miss_i(tlb_miss), .tlb_u_i(tlb_u), .tlb_x_i(tlb_x), .tlb_ptag_i(tlb_ptag),
    .uncached_i(uncached), .kill_o(kill_a), .cache_data_i(cache_data),
    .cache_data_v_i(cache_data_v), .resp_v_o(resp_v_a), .resp_ready_i(rdy_a),
    .resp_o(resp_a));

  bp_fe_mem_pipe #(.stages_p(2), .buf_els_p(2)) dut_b (
    .clk_i(clk), .reset_i(reset_n), .cmd_v_i(cmd_v), .cmd_vaddr_i(cmd_vaddr),
    .cmd_ready_o(ready_b), .poison_i(poison), .priv_i(priv),
    .translation_en_i(trans_en), .uncached_mode_i(unc_mode), .tlb_v_i(tlb_v),
    .tlb_miss_i(tlb_miss), .tlb_u_i(tlb_u), .tlb_x_i(tlb_x), .tlb_ptag_i(tlb_ptag),
    .uncached_i(uncached), .kill_o(kill_b), .cache_data_i(cache_data),
    .cache_data_v_i(cache_data_v), .resp_v_o(resp_v_b), .resp_ready_i(rdy_b),
    .resp_o(resp_b));

  bp_fe_mem_pipe #(.stages_p(2), .buf_els_p(4)) dut_c (
    .clk_i(clk), .reset_i(reset_n), .cmd_v_i(cmd_v), .cmd_vaddr_i(cmd_vaddr),
    .cmd_ready_o(ready_c), .poison_i(poison), .priv_i(priv),
    .translation_en_i(trans_en), .uncached_mode_i(unc_mode), .tlb_v_i(tlb_v),
    .tlb_miss_i(tlb_miss), .tlb_u_i(tlb_u), .tlb_x_i(tlb_x), .tlb_ptag_i(tlb_ptag),
    .uncached_i(uncached), .kill_o(kill_c), .cache_data_i(cache_data),
    .cache_data_v_i(cache_data_v), .resp_v_o(resp_v_c), .resp_ready_i(rdy_c),
    .resp_o(resp_c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic [rw-1:0] r,
                          input logic [vw-1:0] va, input logic [31:0] d, input logic [3:0] fl);
    chk({tag, ".vaddr"}, 64'(r[rw-1:36]), 64'(va));
    chk({tag, ".data"},  64'(r[35:4]),    64'(d));
    chk({tag, ".flags"}, 64'(r[3:0]),     64'(fl));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tlb_defaults();
    priv     = 2'd3;
    trans_en = 1'b1;
    unc_mode = 1'b0;
    tlb_v    = 1'b1;
    tlb_miss = 1'b0;
    tlb_u    = 1'b0;
    tlb_x    = 1'b1;
    tlb_ptag = 28'h0080000;
    uncached = 1'b0;
  endtask

  task automatic do_reset();
    cmd_v = 1'b0; poison = 1'b0; cache_data_v = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic single(input string tag, input logic [vw-1:0] va, input logic [1:0] pv,
                        input logic miss, input logic u, input logic x, input logic [pw-1:0] ptag,
                        input logic um, input logic unc, input logic [31:0] d, input logic dv,
                        input logic exp_kill, input logic [31:0] exp_d, input logic [3:0] exp_fl);
    cmd_v = 1'b1; cmd_vaddr = va;
    settle();
    tick();
    cmd_v = 1'b0;
    priv = pv; tlb_miss = miss; tlb_u = u; tlb_x = x; tlb_ptag = ptag;
    unc_mode = um; uncached = unc;
    settle();
    chk({tag, ".kill"}, 64'(kill_a), 64'(exp_kill));
    tick();
    tlb_defaults();
    cache_data = d; cache_data_v = dv;
    settle();
    tick();
    cache_data_v = 1'b0;
    settle();
    chk({tag, ".resp_v"}, 64'(resp_v_a), 64'd1);
    chk_resp(tag, resp_a, va, exp_d, exp_fl);
    tick();
  endtask

  initial begin
    tlb_defaults();
    cmd_v = 1'b0; cmd_vaddr = '0; poison = 1'b1; cache_data = '0; cache_data_v = 1'b0;
    rdy_a = 1'b1; rdy_b = 1'b0; rdy_c = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    settle();
    chk("rst.cmd_ready", 64'(ready_a), 64'd1);
    chk("rst.resp_v",    64'(resp_v_a), 64'd0);
    chk("rst.resp",      64'(resp_a[63:0]), 64'd0);
    chk("rst.kill_p1",   64'(kill_a), 64'd1);
    poison = 1'b0;
    settle();
    chk("rst.kill_p0",   64'(kill_a), 64'd0);
    tick();
    reset_n = 1'b1;

    // back-to-back stream on the 3-deep instance
    cmd_v = 1'b1; cmd_vaddr = 39'h0_8000_0000;
    settle(); chk("strm.ready0", 64'(ready_a), 64'd1); tick();
    cmd_vaddr = 39'h0_8000_0004;
    settle(); chk("strm.ready1", 64'(ready_a), 64'd1); tick();
    cmd_vaddr = 39'h0_8000_0008; cache_data = 32'h1111_1111; cache_data_v = 1'b1;
    settle(); chk("strm.ready2", 64'(ready_a), 64'd1); tick();
    cmd_v = 1'b0; cache_data = 32'h2222_2222;
    settle(); chk("strm.v3", 64'(resp_v_a), 64'd1);
    chk_resp("strm.r3", resp_a, 39'h0_8000_0000, 32'h1111_1111, 4'b0000); tick();
    cache_data = 32'h3333_3333;
    settle(); chk("strm.v4", 64'(resp_v_a), 64'd1);
    chk_resp("strm.r4", resp_a, 39'h0_8000_0004, 32'h2222_2222, 4'b0000); tick();
    cache_data_v = 1'b0;
    settle(); chk("strm.v5", 64'(resp_v_a), 64'd1);
    chk_resp("strm.r5", resp_a, 39'h0_8000_0008, 32'h3333_3333, 4'b0000); tick();
    settle(); chk("strm.v6", 64'(resp_v_a), 64'd0); tick();

    // backpressure on the 2-deep instance
    do_reset();
    rdy_b = 1'b0;
    cmd_v = 1'b1; cmd_vaddr = 39'h0_8000_0100;
    settle(); tick();
    cmd_vaddr = 39'h0_8000_0104;
    settle(); chk("bp.ready1", 64'(ready_b), 64'd1); tick();
    cmd_v = 1'b0; cache_data = 32'hAAAA_0001; cache_data_v = 1'b1;
    settle(); chk("bp.ready2", 64'(ready_b), 64'd0); tick();
    cache_data = 32'hAAAA_0002;
    settle(); chk("bp.v3", 64'(resp_v_b), 64'd1);
    chk_resp("bp.r3", resp_b, 39'h0_8000_0100, 32'hAAAA_0001, 4'b0000); tick();
    cache_data_v = 1'b0;
    settle(); chk("bp.ready4", 64'(ready_b), 64'd0);
    chk_resp("bp.r4", resp_b, 39'h0_8000_0100, 32'hAAAA_0001, 4'b0000);
    rdy_b = 1'b1; tick();
    rdy_b = 1'b0;
    settle(); chk("bp.ready5", 64'(ready_b), 64'd1);
    chk_resp("bp.r5", resp_b, 39'h0_8000_0104, 32'hAAAA_0002, 4'b0000); tick();
    settle(); chk("bp.v6", 64'(resp_v_b), 64'd1);
    chk_resp("bp.r6", resp_b, 39'h0_8000_0104, 32'hAAAA_0002, 4'b0000); tick();

    // classification vectors on the 3-deep instance
    do_reset();
    rdy_a = 1'b1;
    single("miss_prio",   39'h0_8000_0200, 2'd3, 1'b1, 1'b0, 1'b1, 28'h0000000, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0, 4'b1000);
    single("pf_user",     39'h0_8000_0204, 2'd0, 1'b0, 1'b0, 1'b1, 28'h0080000, 1'b0, 1'b0, 32'h0101_0101, 1'b1, 1'b1, 32'h0, 4'b0100);
    single("pf_super_u",  39'h0_8000_0208, 2'd1, 1'b0, 1'b1, 1'b1, 28'h0080000, 1'b0, 1'b0, 32'h0202_0202, 1'b1, 1'b1, 32'h0, 4'b0100);
    single("ok_super",    39'h0_8000_020C, 2'd1, 1'b0, 1'b0, 1'b1, 28'h0080000, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678, 4'b0000);
    single("af_low",      39'h0_8000_0210, 2'd3, 1'b0, 1'b0, 1'b1, 28'h007FFFF, 1'b0, 1'b0, 32'h0303_0303, 1'b1, 1'b1, 32'h0, 4'b0010);
    single("af_did",      39'h0_8000_0214, 2'd3, 1'b0, 1'b0, 1'b1, 28'h2080000, 1'b0, 1'b0, 32'h0404_0404, 1'b1, 1'b1, 32'h0, 4'b0010);
    single("af_unc",      39'h0_8000_0218, 2'd3, 1'b0, 1'b0, 1'b1, 28'h0080000, 1'b1, 1'b0, 32'h0505_0505, 1'b1, 1'b1, 32'h0, 4'b0010);
    single("pf_noexec",   39'h0_8000_021C, 2'd3, 1'b0, 1'b0, 1'b0, 28'h0080000, 1'b0, 1'b0, 32'h0606_0606, 1'b1, 1'b1, 32'h0, 4'b0100);
    single("miss_ovr_pf", 39'h0_8000_0220, 2'd0, 1'b1, 1'b0, 1'b1, 28'h0080000, 1'b0, 1'b0, 32'h0707_0707, 1'b1, 1'b1, 32'h0, 4'b1000);
    single("icache_miss", 39'h0_8000_0224, 2'd3, 1'b0, 1'b0, 1'b1, 28'h0080000, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0BAD_F00D, 4'b0001);
    single("user_ok",     39'h0_8000_0228, 2'd0, 1'b0, 1'b1, 1'b1, 28'h0080000, 1'b0, 1'b0, 32'hCAFE_0001, 1'b1, 1'b0, 32'hCAFE_0001, 4'b0000);
    single("unc_ok",      39'h0_8000_022C, 2'd3, 1'b0, 1'b0, 1'b1, 28'h0080000, 1'b1, 1'b1, 32'hCAFE_0002, 1'b1, 1'b0, 32'hCAFE_0002, 4'b0000);

    // poison with 2 in flight + 1 buffered, on the 4-deep instance
    do_reset();
    rdy_c = 1'b0;
    cmd_v = 1'b1; cmd_vaddr = 39'h0_8000_0300; settle(); tick();
    cmd_vaddr = 39'h0_8000_0304; settle(); tick();
    cmd_vaddr = 39'h0_8000_0308; cache_data = 32'hC000_0000; cache_data_v = 1'b1;
    settle(); tick();
    cmd_vaddr = 39'h0_8000_030C; cache_data = 32'hC000_0001; poison = 1'b1;
    settle();
    chk("psn.v_before", 64'(resp_v_c), 64'd1);
    chk("psn.ready",    64'(ready_c), 64'd1);
    chk("psn.kill",     64'(kill_c), 64'd1);
    tick();
    poison = 1'b0; cmd_vaddr = 39'h0_8000_0310; cache_data = 32'hC000_0002;
    settle(); chk("psn.v_p1", 64'(resp_v_c), 64'd0); tick();
    cmd_vaddr = 39'h0_8000_0314; cache_data = 32'hD0D0_D0D0;
    settle(); chk("psn.v_p2", 64'(resp_v_c), 64'd0); tick();
    cmd_vaddr = 39'h0_8000_0318; cache_data = 32'hE0E0_E0E0;
    settle(); chk("psn.v_p3", 64'(resp_v_c), 64'd1);
    chk_resp("psn.r_p3", resp_c, 39'h0_8000_030C, 32'hD0D0_D0D0, 4'b0000);
    chk("psn.ready_p3", 64'(ready_c), 64'd1); tick();
    cmd_v = 1'b0; cache_data = 32'hF0F0_F0F0;
    settle(); chk("psn.ready_full", 64'(ready_c), 64'd0);
    chk_resp("psn.r_p4", resp_c, 39'h0_8000_030C, 32'hD0D0_D0D0, 4'b0000); tick();
    cache_data_v = 1'b0;

    // reset mid-stream on the 3-deep instance
    do_reset();
    rdy_a = 1'b0;
    cmd_v = 1'b1; cmd_vaddr = 39'h0_8000_0400; settle(); tick();
    cmd_vaddr = 39'h0_8000_0404; settle(); tick();
    cmd_vaddr = 39'h0_8000_0408; cache_data = 32'h4444_0000; cache_data_v = 1'b1;
    settle(); tick();
    cmd_v = 1'b0; cache_data = 32'h4444_0001;
    settle(); chk("mrst.v_before", 64'(resp_v_a), 64'd1);
    chk("mrst.ready_before", 64'(ready_a), 64'd0);
    reset_n = 1'b0; tick();
    reset_n = 1'b1; cache_data = 32'h4444_0002;
    settle();
    chk("mrst.v",     64'(resp_v_a), 64'd0);
    chk("mrst.ready", 64'(ready_a), 64'd1);
    chk("mrst.resp",  64'(resp_a[63:0]), 64'd0);
    tick();
    cache_data_v = 1'b0;
    settle(); chk("mrst.v_next", 64'(resp_v_a), 64'd0); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_fe_mem_pipe.md
# bp_fe_mem_pipe

Parametrised front-end fetch-tracking pipeline and the successor to the fixed two-cycle fetch response path. It accepts fetch commands and carries each fetch through a configurable-depth pipeline. Translation results from the external ITLB and data from the external I$ are paired with their fetch, and faults are classified with a fixed priority. Results are held in a response buffer with ready/valid backpressure. It sits between the fetch PC generator and the backend fetch queue, and adds multi-instruction fetch width, a credit-based command ready and response stall support.

## Interface
- vaddr_width_p, 39, virtual address width
- ptag_width_p, 28, physical tag width
- page_offset_width_p, 12, page offset bits
- fetch_width_p, 1, 32-bit instructions returned per fetch (1, 2 or 4)
- stages_p, 2, cycles from command accept to cache data (≥2)
- buf_els_p, 2, response buffer depth; also maximum fetches in flight plus buffered (≥1)
- io_did_width_p, 3, top ptag bits holding the domain id
- dram_base_ptag_p, 'h80000, lowest cacheable-speculative ptag

Ports:
- clk_i in 1: clock. Reset is synchronous, active-low.
- reset_i in 1: synchronous, active-low reset.
- cmd_v_i in 1: fetch command valid.
- cmd_vaddr_i in vaddr_width_p: fetch address.
- cmd_ready_o out 1: command accepted when cmd_v_i & cmd_ready_o.
- poison_i in 1: redirect; kills all in-flight and buffered fetches.
- priv_i in 2: current privilege (U=0, S=1, M=3).
- translation_en_i in 1: translation enabled.
- uncached_mode_i in 1: I$ configured uncached.
- tlb_v_i, tlb_miss_i, tlb_u_i, tlb_x_i in 1 each: ITLB result, valid at accept+1.
- tlb_ptag_i in ptag_width_p: ITLB result, valid at accept+1.
- uncached_i in 1: PMA result for tlb_ptag_i, valid at accept+1.
- kill_o out 1: combinational; stage-1 fault or poison, driven to the I$ poison input.
- cache_data_i in 32*fetch_width_p: I$ data, valid at accept+stages_p.
- cache_data_v_i in 1: I$ data valid, at accept+stages_p.
- resp_v_o out 1: response valid.
- resp_ready_i in 1: response consumer ready.
- resp_o out: bp_fe_mem_pipe_resp_s {vaddr, data, itlb_miss, instr_page_fault, instr_access_fault, icache_miss}.

## Operation
- Valid shift register stage[1..stages_p], each stage carrying its vaddr. Stage 1 also latches the classification.
- Credits: count = stage occupancy + buffer occupancy. cmd_ready_o = (count < buf_els_p). The count is clog2(buf_els_p+1) bits and never exceeds buf_els_p.
- Classification at stage 1, from tlb_*:
  - itlb_miss = tlb_miss_i.
  - page fault = translation_en_i & tlb_v_i & (~tlb_x_i | (priv==S & tlb_u_i) | (priv==U & ~tlb_u_i)).
  - access fault = (uncached_mode_i & ~uncached_i) | (ptag top io_did_width_p bits ≠ 0) | (ptag < dram_base_ptag_p).
- Priority: itlb_miss > page fault > access fault. At most one flag is set. Any flag forces icache_miss=0.
- kill_o = poison_i | (stage1 valid & any fault).
- At stage stages_p: icache_miss = no fault & ~cache_data_v_i. data = cache_data_i, or zero if a fault is flagged. The entry is enqueued into the buffer.
- Poison:
  - Clears all stage valids and empties the buffer.
  - A command accepted in the poison cycle survives, so count becomes 1.
  - resp_v_o falls the cycle after poison.

## Timing
- Reset values: cmd_ready_o=1, resp_v_o=0, kill_o=poison_i, resp_o=0, count=0.
- Command accepted in cycle t:
  - tlb_* sampled in cycle t+1.
  - cache_data sampled in cycle t+stages_p.
  - Earliest resp_v_o in cycle t+stages_p+1. The buffer is registered with no bypass.
- Throughput is one fetch per cycle when buf_els_p ≥ stages_p+1 and resp_ready_i is held high.
- Same-cycle dequeue and enqueue on a full buffer is allowed. The dequeued credit is visible on cmd_ready_o in the next cycle only.
- resp_o is stable while resp_v_o & ~resp_ready_i.
- Reset asserted mid-operation discards everything in the next cycle.

## Structure
- bp_fe_pkg holds:
  - bp_fe_mem_pipe_resp_s, declared through a macro parametrised by vaddr_width_p and fetch_width_p.
  - The fault-priority enum {e_fe_fault_none, e_fe_fault_itlb_miss, e_fe_fault_page, e_fe_fault_access}.
  - The privilege constants.
- One sub-module: bsg_fifo_1r1w_small (els_p=buf_els_p) as the response buffer. The sub-module's reset is driven with ~reset_i | poison_i.
- Classification stays inline.

## Test plan
- Back-to-back stream, stages_p=2, buf_els_p=3, resp_ready_i=1:
  - Stimulus: vaddrs 0x8000_0000, 0x8000_0004 and 0x8000_0008 accepted in cycles 0, 1 and 2.
  - Required: responses in cycles 3, 4 and 5 in order, with data matched and no flags set.
- Backpressure, buf_els_p=2, resp_ready_i=0:
  - Stimulus: 2 commands accepted.
  - Required: cmd_ready_o=0 from the following cycle. After resp_ready_i=1 for one cycle, cmd_ready_o=1 one cycle later and resp_o is unchanged while stalled.
- Priority:
  - Stimulus: tlb_miss_i=1 with ptag=0 (also an access-fault condition).
  - Required: itlb_miss=1, access fault=0, icache_miss=0, data=0, kill_o=1 in cycle t+1.
- Privilege:
  - Stimulus: priv=U, translation_en_i=1, tlb_u_i=0, tlb_x_i=1.
  - Required: instr_page_fault=1.
  - Stimulus: same with priv=S and tlb_u_i=1.
  - Required: instr_page_fault=1.
  - Stimulus: priv=S, tlb_u_i=0.
  - Required: no fault.
- Poison:
  - Stimulus: 2 in flight plus 1 buffered, then poison_i together with a new accept.
  - Required: only the new fetch is returned, count=1 after poison, and resp_v_o=0 in cycle poison+1.
- Miss and reset:
  - Stimulus: cache_data_v_i=0 at stage stages_p.
  - Required: icache_miss=1.
  - Stimulus: reset_i=0 mid-stream.
  - Required: resp_v_o=0 and cmd_ready_o=1 the next cycle.
